uart_rx_core: RTL and testbench

Oversampling UART receiver that consumes the single-cycle baud strobe produced by the baud-rate prescaler logic. It recovers 8N1 frames from the serial `rx` line and presents each byte through a valid/ack holding register. Framing and overrun errors are reported alongside the byte. It is the receive end of the UART link that feeds the sine-wave control registers.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx_core.sv | 144 ++++++++++++++
 tb/tb_uart_rx_core.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte hand-off bundle between the UART receiver and its consumer.
// The receiver drives data and status; the consumer returns the ack.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1 UART receiver driven by a baud*OVERSAMPLE strobe.
// Holds each received byte with framing/overrun status until acknowledged.
module uart_rx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic     src_clk,
    input  logic     rst_n,
    input  logic     baud_tick,
    input  logic     rx,
    output logic     busy,
    uart_rx_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state, state_n;
    logic                 s1, rx_s;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tcnt_clr, tcnt_inc;
    logic                 bcnt_clr, shift, commit;
    logic                 ack_take;

    assign busy     = (state != IDLE);
    assign ack_take = bus.rx_ack & bus.rx_valid;

    // Two-flop synchronizer, preset to the idle-high line level
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= rx;
            rx_s <= s1;
        end
    end

    // FSM state register
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and datapath control
    always_comb begin
        state_n  = state;
        tcnt_clr = 1'b0;
        tcnt_inc = 1'b0;
        bcnt_clr = 1'b0;
        shift    = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n  = START;
                    tcnt_clr = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tcnt == T_HALF) begin
                        tcnt_clr = 1'b1;
                        bcnt_clr = 1'b1;
                        state_n  = rx_s ? IDLE : DATA;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tcnt == T_LAST) begin
                        shift    = 1'b1;
                        tcnt_clr = 1'b1;
                        if (bcnt == B_LAST) state_n = STOP;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tcnt == T_LAST) begin
                        commit  = 1'b1;
                        state_n = rx_s ? IDLE : BRK;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Tick/bit counters and LSB-first shift register
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            if (tcnt_clr)      tcnt <= '0;
            else if (tcnt_inc) tcnt <= tcnt + 1'b1;
            if (bcnt_clr)      bcnt <= '0;
            else if (shift)    bcnt <= bcnt + 1'b1;
            if (shift)         shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    // Holding register: commit beats ack; unacked commit flags overrun
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (commit) begin
            bus.rx_data   <= shreg;
            bus.frame_err <= ~rx_s;
            bus.rx_valid  <= 1'b1;
            if (bus.rx_valid && !bus.rx_ack) bus.overrun <= 1'b1;
            else if (ack_take)               bus.overrun <= 1'b0;
        end else if (ack_take) begin
            bus.rx_valid <= 1'b0;
            bus.overrun  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed + randomized frames against a byte-level model.
// All inputs change on the falling clock edge; outputs are read there too.
module tb_uart_rx_core;
    localparam int OS   = 16;
    localparam int TPB  = 4;
    localparam int BITC = OS * TPB;
    localparam int COMMIT_TICK = OS / 2 + 9 * OS;

    logic clk = 1'b0;
    logic rst_n;
    logic baud_tick;
    logic rx;
    logic busy;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx_core #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .src_clk  (clk),
        .rst_n    (rst_n),
        .baud_tick(baud_tick),
        .rx       (rx),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ph     = 0;
    int nstep  = 0;
    int tk     = 0;
    bit collide = 1'b0;

    // model of the holding register
    logic [7:0] exp_data;
    bit exp_valid, exp_fe, exp_ov;
    int exp_rises;

    // observed rx_valid rising edges
    int rises = 0;
    logic pv = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.rx_valid && !pv) rises++;
        pv = bus.rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: advance the tick strobe, track ticks since start edge
    task automatic step();
        @(negedge clk);
        baud_tick = (ph == 0);
        ph = (ph + 1) % TPB;
        nstep++;
        if (baud_tick && nstep >= 3) tk++;
        if (collide)
            bus.rx_ack = baud_tick && nstep >= 3 && tk == COMMIT_TICK;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mreset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
        exp_rises = 0;
    endtask

    task automatic mcommit(input logic [7:0] d, input bit stopb, input bit ackc);
        if (exp_valid && !ackc) exp_ov = 1'b1;
        else if (exp_valid && ackc) exp_ov = 1'b0;
        if (!exp_valid) exp_rises++;
        exp_valid = 1'b1;
        exp_data  = d;
        exp_fe    = !stopb;
    endtask

    task automatic send(input logic [7:0] d, input bit stopb, input bit col);
        logic [9:0] fr;
        fr = {stopb, d, 1'b0};
        collide = col;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            if (i == 0) begin
                nstep = 0;
                tk    = 0;
            end
            steps(BITC);
        end
        collide = 1'b0;
        bus.rx_ack = 1'b0;
        mcommit(d, stopb, col);
    endtask

    task automatic ack();
        bus.rx_ack = 1'b1;
        step();
        bus.rx_ack = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ov    = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  bus.rx_data, exp_data);
        check({tag, ".valid"}, bus.rx_valid, exp_valid);
        check({tag, ".ferr"},  bus.frame_err, exp_fe);
        check({tag, ".ovr"},   bus.overrun, exp_ov);
        check({tag, ".rises"}, rises, exp_rises);
    endtask

    initial begin
        logic [7:0] d;
        bit sb, do_ack;
        rst_n      = 1'b0;
        rx         = 1'b1;
        baud_tick  = 1'b0;
        bus.rx_ack = 1'b0;
        mreset();
        steps(5);
        rst_n = 1'b1;
        steps(5);
        check_all("reset");
        check("reset.busy", busy, 1'b0);

        // reset in the middle of a frame
        rx = 1'b0;
        steps(BITC);
        rx = 1'b1;
        steps(BITC);
        check("mid.busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async.busy", busy, 1'b0);
        steps(3);
        rst_n = 1'b1;
        steps(12 * BITC);
        rises = 0;
        check_all("midrst");
        check("midrst.busy", busy, 1'b0);

        // single byte then ack
        send(8'hA5, 1'b1, 1'b0);
        steps(BITC);
        check_all("a5");
        check("a5.busy", busy, 1'b0);
        ack();
        check_all("a5ack");
        ack();
        check_all("idleack");

        // glitch shorter than half a bit
        rx = 1'b0;
        steps(4 * TPB);
        rx = 1'b1;
        steps(2 * BITC);
        check_all("glitch");
        check("glitch.busy", busy, 1'b0);

        // framing error followed by a held-low break
        send(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        steps(3 * BITC);
        check_all("brk");
        check("brk.busy", busy, 1'b1);
        rx = 1'b1;
        steps(BITC);
        check("brk.idle", busy, 1'b0);
        check_all("brk.end");
        ack();
        check_all("brk.ack");

        // back-to-back without ack
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        steps(BITC);
        check_all("ovr");
        ack();
        check_all("ovr.ack");

        // ack landing on the commit cycle of the second byte
        send(8'h5A, 1'b1, 1'b0);
        send(8'hC3, 1'b1, 1'b1);
        steps(BITC);
        check_all("coll");

        // randomized frames
        for (int n = 0; n < 10; n++) begin
            d      = 8'($urandom);
            sb     = ($urandom_range(3) != 0);
            do_ack = $urandom_range(1) != 0;
            if (do_ack) ack();
            send(d, sb, 1'b0);
            rx = 1'b1;
            steps(BITC);
            check_all("rnd");
            check("rnd.busy", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
